// File: rtl/prod_accum_seq_if.sv
// Product-in / sum-out handshake bundle for prod_accum_seq, plus the frame clear and status.
// The master side drives products and accepts results; the slave side is the accumulator.
interface prod_accum_seq_if #(
  parameter int N     = 4,
  parameter int LEN   = 4,
  parameter int ACC_W = 2*N+4
);
  localparam int CW = $clog2(LEN) + 1;

  logic             clr;
  logic             prod_valid;
  logic             prod_ready;
  logic [2*N-1:0]   prod;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res;
  logic             ovf;
  logic [CW-1:0]    cnt;

  modport master (
    output clr, prod_valid, prod, res_ready,
    input  prod_ready, res_valid, res, ovf, cnt
  );

  modport slave (
    input  clr, prod_valid, prod, res_ready,
    output prod_ready, res_valid, res, ovf, cnt
  );
endinterface

// File: rtl/prod_accum_seq.sv
// Sums LEN consecutive 2N-bit products into a registered ACC_W-bit result with sticky overflow.
// res_valid rises on the edge accepting the LEN-th product; prod_ready stays low until the result is popped.
module prod_accum_seq #(
  parameter int N     = 4,
  parameter int LEN   = 4,
  parameter int ACC_W = 2*N+4
) (
  input logic             clk,
  input logic             rst_n,
  prod_accum_seq_if.slave bus
);
  localparam int CW = $clog2(LEN) + 1;

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  logic [0:0]       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] res_q;
  logic [ACC_W:0]   sum;
  logic [CW-1:0]    cnt_q;
  logic             ovf_q;
  logic             res_valid_q;
  logic             take;

  assign take = bus.prod_valid && (state == ACCUM);

  // The spare top bit of the adder is the carry out of the accumulator MSB.
  assign sum = {1'b0, acc} + (ACC_W+1)'(bus.prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ACCUM;
      acc         <= '0;
      cnt_q       <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (bus.clr) begin
      // Abort the frame and drop any pending result, but keep the last res value.
      state       <= ACCUM;
      acc         <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (take) begin
            acc   <= sum[ACC_W-1:0];
            cnt_q <= cnt_q + CW'(1);
            if (sum[ACC_W]) begin
              ovf_q <= 1'b1;
            end
            if (cnt_q == LAST) begin
              res_q       <= sum[ACC_W-1:0];
              res_valid_q <= 1'b1;
              state       <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            acc         <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            state       <= ACCUM;
          end
        end
        default: begin
          state <= ACCUM;
        end
      endcase
    end
  end

  assign bus.prod_ready = (state == ACCUM);
  assign bus.res_valid  = res_valid_q;
  assign bus.res        = res_q;
  assign bus.ovf        = ovf_q;
  assign bus.cnt        = cnt_q;
endmodule
